// File: rtl/f64_promote_unit_if.sv
// Handshake bundle for the f32->f64 promote unit: operand in, result out, busy flag.
// Latency: n/a (wires only).
// Backpressure: out_ready stalls the producer side; in_ready stalls the operand source.
interface f64_promote_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    // Unit side: consumes operands, produces results.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );

    // Client side: supplies operands, takes results.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );
endinterface

// File: rtl/f64_promote_unit.sv
// WebAssembly f64.promote_f32: widens an IEEE-754 binary32 operand to binary64.
// Latency: 1 cycle to result, plus (23-k) cycles for a subnormal with leading one at bit k when SERIAL_NORM=1.
// Backpressure: one operand in flight; in_ready low until the result handshakes, result held while out_ready=0.
module f64_promote_unit #(
    parameter bit SERIAL_NORM = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    f64_promote_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        sign_q;
    logic [23:0] m_q;
    logic [10:0] x_q;
    logic [63:0] out_data_q;

    // Operand fields
    logic        in_s;
    logic [7:0]  in_e;
    logic [22:0] in_f;
    logic        in_is_sub;
    logic        accept;

    assign in_s      = bus.in_data[31];
    assign in_e      = bus.in_data[30:23];
    assign in_f      = bus.in_data[22:0];
    assign in_is_sub = (in_e == 8'd0) && (in_f != 23'd0);
    assign accept    = bus.in_valid && bus.in_ready;

    // Leading-one position of the fraction, used by the single-cycle normalizer.
    logic [4:0] lead_k;
    always_comb begin
        lead_k = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (in_f[i]) lead_k = 5'(i);
        end
    end

    logic [22:0] pe_frac;
    logic [10:0] pe_x;
    assign pe_frac = 23'(in_f << (5'd23 - lead_k));
    assign pe_x    = 11'd874 + {6'd0, lead_k};

    // Result for every class that does not need the serial normalizer.
    logic [63:0] direct_res;
    always_comb begin
        direct_res = 64'd0;
        if (in_e == 8'hFF) begin
            if (in_f == 23'd0) begin
                direct_res = {in_s, 11'h7FF, 52'd0};
            end else begin
                // Payload kept, quiet bit forced so a signalling NaN comes out quiet.
                direct_res = {in_s, 11'h7FF, 1'b1, in_f[21:0], 29'd0};
            end
        end else if (in_e == 8'd0) begin
            if (in_f == 23'd0) begin
                direct_res = {in_s, 63'd0};
            end else begin
                direct_res = {in_s, pe_x, pe_frac, 29'd0};
            end
        end else begin
            direct_res = {in_s, {3'd0, in_e} + 11'd896, in_f, 29'd0};
        end
    end

    // One normalization step: shift the mantissa up, drop the exponent by one.
    logic [23:0] m_shl;
    logic [10:0] x_dec;
    logic        norm_end;
    logic [22:0] norm_frac;
    logic [10:0] norm_x;

    assign m_shl = {m_q[22:0], 1'b0};
    assign x_dec = x_q - 11'd1;
    // Finish on the step whose shift lands the leading one in bit 23; the
    // m_q[23] case never arises from a load but keeps the loop closed.
    assign norm_end  = m_q[23] || m_shl[23];
    assign norm_frac = m_q[23] ? m_q[22:0] : m_shl[22:0];
    assign norm_x    = m_q[23] ? x_q : x_dec;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_is_sub && SERIAL_NORM) state_nxt = NORM;
                    else                          state_nxt = DONE;
                end
            end
            NORM: begin
                if (norm_end) state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, serial normalization, result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q     <= 1'b0;
            m_q        <= 24'd0;
            x_q        <= 11'd0;
            out_data_q <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q <= in_s;
                        if (in_is_sub && SERIAL_NORM) begin
                            m_q <= {1'b0, in_f};
                            x_q <= 11'd897;
                        end else begin
                            out_data_q <= direct_res;
                        end
                    end
                end
                NORM: begin
                    m_q <= m_shl;
                    x_q <= x_dec;
                    if (norm_end) begin
                        out_data_q <= {sign_q, norm_x, norm_frac, 29'd0};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_f64_promote_unit.sv
// Randomized + directed bench for f64_promote_unit, serial and single-cycle variants side by side.
// Latency: n/a.
// Backpressure: exercises held out_ready and ignored operands while a result is pending.
module tb_f64_promote_unit;

    logic clk;
    logic reset;

    f64_promote_unit_if ifa ();
    f64_promote_unit_if ifb ();

    f64_promote_unit #(.SERIAL_NORM(1'b1)) u_serial (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    f64_promote_unit #(.SERIAL_NORM(1'b0)) u_parallel (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: derive the binary64 value from the binary32 number's meaning.
    function automatic logic [63:0] ref_promote(input logic [31:0] a);
        logic        s;
        int          e;
        longint      f;
        longint      mant;
        longint      bexp;
        int          k;
        s = a[31];
        e = int'(a[30:23]);
        f = longint'(a[22:0]);
        if (e == 255) begin
            bexp = 2047;
            if (f == 0) mant = 0;
            else        mant = (f << 29) | (longint'(1) << 51);
        end else if (e == 0 && f == 0) begin
            bexp = 0;
            mant = 0;
        end else if (e == 0) begin
            // value = f * 2^-149, leading one at bit k -> unbiased exponent k-149
            k = 0;
            for (int i = 0; i < 23; i++) if (f[i]) k = i;
            bexp = longint'(k - 149 + 1023);
            mant = (f << (52 - k)) & ((longint'(1) << 52) - 1);
        end else begin
            bexp = longint'(e - 127 + 1023);
            mant = f << 29;
        end
        ref_promote = {s, 63'd0} | 64'(bexp << 52) | 64'(mant);
    endfunction

    function automatic int ref_latency(input logic [31:0] a, input bit serial);
        int k;
        if (serial && a[30:23] == 8'd0 && a[22:0] != 23'd0) begin
            k = 0;
            for (int i = 0; i < 23; i++) if (a[i]) k = i;
            ref_latency = 1 + (23 - k);
        end else begin
            ref_latency = 1;
        end
    endfunction

    function automatic logic get_ov(input bit w);
        get_ov = w ? ifb.out_valid : ifa.out_valid;
    endfunction
    function automatic logic [63:0] get_od(input bit w);
        get_od = w ? ifb.out_data : ifa.out_data;
    endfunction
    function automatic logic get_ir(input bit w);
        get_ir = w ? ifb.in_ready : ifa.in_ready;
    endfunction
    function automatic logic get_busy(input bit w);
        get_busy = w ? ifb.busy : ifa.busy;
    endfunction

    task automatic set_in(input bit w, input logic v, input logic [31:0] d);
        if (w) begin ifb.in_valid = v; ifb.in_data = d; end
        else   begin ifa.in_valid = v; ifa.in_data = d; end
    endtask

    task automatic set_ordy(input bit w, input logic r);
        if (w) ifb.out_ready = r;
        else   ifa.out_ready = r;
    endtask

    // One full transaction: accept, wait for result, optional stall, handshake.
    task automatic do_op(input bit w, input logic [31:0] d, input logic [63:0] exp,
                         input int exp_lat, input int hold);
        int lat;
        set_ordy(w, hold == 0);
        @(negedge clk);
        check("in_ready_idle", 64'(get_ir(w)), 64'd1);
        set_in(w, 1'b1, d);
        @(posedge clk);
        #1;
        set_in(w, 1'b0, $urandom);
        lat = 1;
        while (!get_ov(w) && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("out_data", get_od(w), exp);
        check("busy_done", 64'(get_busy(w)), 64'd1);
        for (int i = 0; i < hold; i++) begin
            set_in(w, 1'b1, $urandom);
            @(posedge clk);
            #1;
            check("hold_valid", 64'(get_ov(w)), 64'd1);
            check("hold_data", get_od(w), exp);
            check("hold_in_ready", 64'(get_ir(w)), 64'd0);
        end
        set_in(w, 1'b0, 32'd0);
        set_ordy(w, 1'b1);
        @(posedge clk);
        #1;
        check("post_valid", 64'(get_ov(w)), 64'd0);
        check("post_busy", 64'(get_busy(w)), 64'd0);
        check("post_in_ready", 64'(get_ir(w)), 64'd1);
        check("post_data_kept", get_od(w), exp);
    endtask

    // Directed cases: operand, required result, latency on the serial unit.
    logic [31:0] dir_in  [6] = '{32'hC0000000, 32'h00000001, 32'h00400000,
                                 32'h7FA00000, 32'h80000000, 32'hFF800000};
    logic [63:0] dir_out [6] = '{64'hC000000000000000, 64'h36A0000000000000, 64'h3800000000000000,
                                 64'h7FFC000000000000, 64'h8000000000000000, 64'hFFF0000000000000};
    int          dir_lat [6] = '{1, 24, 2, 1, 1, 1};

    initial begin
        logic [31:0] d;
        logic [22:0] f;
        bit          w;
        int          cls;

        reset = 1'b1;
        set_in(1'b0, 1'b0, 32'd0);
        set_in(1'b1, 1'b0, 32'd0);
        set_ordy(1'b0, 1'b1);
        set_ordy(1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(ifa.out_valid), 64'd0);
        check("rst_data", ifa.out_data, 64'd0);
        check("rst_busy", 64'(ifa.busy), 64'd0);
        check("rst_in_ready", 64'(ifa.in_ready), 64'd0);
        check("rst_in_ready_b", 64'(ifb.in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_op(1'b0, dir_in[i], dir_out[i], dir_lat[i], 0);
        end
        // Single-cycle normalizer on the minimum subnormal.
        do_op(1'b1, 32'h00000001, 64'h36A0000000000000, 1, 0);
        // Five-cycle stall in DONE with an operand presented meanwhile.
        do_op(1'b0, 32'h3F800000, 64'h3FF0000000000000, 1, 5);

        // Reset in the middle of a serial normalization.
        set_ordy(1'b0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 1'b1, 32'h00000001);
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b0, 32'd0);
        repeat (5) @(posedge clk);
        #3;
        check("norm_busy", 64'(ifa.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_valid", 64'(ifa.out_valid), 64'd0);
        check("midrst_data", ifa.out_data, 64'd0);
        check("midrst_busy", 64'(ifa.busy), 64'd0);
        check("midrst_in_ready", 64'(ifa.in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op(1'b0, 32'h3F800000, 64'h3FF0000000000000, 1, 0);

        // Random operands across all classes on both variants.
        for (int n = 0; n < 80; n++) begin
            w   = 1'($urandom_range(0, 1));
            cls = int'($urandom_range(0, 4));
            d   = {1'($urandom_range(0, 1)), 31'd0};
            case (cls)
                0: begin
                    f = 23'($urandom) >> $urandom_range(0, 22);
                    if (f == 23'd0) f = 23'd1;
                    d[22:0] = f;
                end
                1: begin
                    d[30:23] = 8'($urandom_range(1, 254));
                    d[22:0]  = 23'($urandom);
                end
                2: ;
                3: d[30:23] = 8'hFF;
                default: begin
                    f = 23'($urandom);
                    if (f == 23'd0) f = 23'd5;
                    d[30:23] = 8'hFF;
                    d[22:0]  = f;
                end
            endcase
            do_op(w, d, ref_promote(d), ref_latency(d, !w), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/f64_promote_unit.md
# f64_promote_unit

Sequential f32→f64 conversion unit implementing WebAssembly `f64.promote_f32`. It is the inverse of the core's `f32.demote_f64` path. It sits beside the core's FPU datapath and is instantiated only when `HAS_FPU && USE_64B`. Operands enter and results leave over valid/ready handshakes. Subnormal inputs are normalized iteratively, one bit per cycle, to keep area small.

## Interface
- `SERIAL_NORM`, default 1: 1 = one-bit-per-cycle subnormal normalization; 0 = single-cycle priority-encoder normalization.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds an f32 operand.
- `in_ready`  out  1  unit can accept an operand.
- `in_data`  in  32  IEEE-754 binary32 operand.
- `out_valid`  out  1  `out_data` holds the promoted result.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  64  IEEE-754 binary64 result.
- `busy`  out  1  state is not IDLE.

## Operation
- Input fields: s = `in_data[31]`, e = `in_data[30:23]`, f = `in_data[22:0]`.
- States: IDLE, NORM, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`, latch s and classify the operand.
  - Classes NORM_NUM, ZERO, INF and NaN go to DONE; SUBNORMAL goes to NORM.
- Normal (1≤e≤254): result = {s, e+11'd896, f, 29'b0}.
- Zero (e=0, f=0): result = {s, 63'b0}. Sign is preserved.
- Infinity (e=255, f=0): result = {s, 11'h7FF, 52'b0}.
- NaN (e=255, f≠0): result = {s, 11'h7FF, 1'b1, f[21:0], 29'b0}.
  - Payload is preserved.
  - Quiet bit 51 is forced to 1, so sNaN becomes qNaN.
- Subnormal (e=0, f≠0)
  - Load 24-bit register m = {1'b0, f} and 11-bit exponent x = 897.
  - NORM: each cycle, while m[23]=0, m <= m<<1 and x <= x−1.
  - When m[23]=1, go to DONE with result = {s, x, m[22:0], 29'b0}.
  - With the leading one of f at bit k, the final x = k+874 and NORM takes 23−k shift cycles.
- `SERIAL_NORM`=0: subnormals are normalized in the accept cycle and go straight to DONE. NORM is unused.
- DONE
  - `out_valid`=1 and `out_data` is held stable.
  - On `out_ready`, go to IDLE.
  - `out_data` keeps its last value after the handshake.
- `in_ready`=0 in NORM and DONE. No new operand is accepted until the result is consumed.
- Widths: all exponent arithmetic is 11-bit unsigned and cannot overflow or underflow (range 874..1150).

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, `busy`=0, m=0, x=0. `in_ready`=0 while `reset` is high.
- Latency, accept edge at cycle N:
  - non-subnormal inputs (and all inputs when `SERIAL_NORM`=0): `out_valid` at N+1;
  - subnormal inputs with `SERIAL_NORM`=1: `out_valid` at N+1+(23−k).
- Throughput: at most one operand per 2 cycles. IDLE is re-entered the cycle after the output handshake.
- Backpressure: `out_valid` and `out_data` stay stable for as long as `out_ready`=0.
- Reset asserted mid-operation (NORM or DONE): immediate return to the reset values and the in-flight result is discarded. The first accept is possible on the first rising edge after release.

## Test plan
- `in_data`=0xC0000000 with `out_ready`=1 -> `out_data`=0xC000000000000000 with `out_valid` one cycle after accept.
- 0x00000001 (minimum subnormal) -> 0x36A0000000000000 with `out_valid` 24 cycles after accept.
- 0x00400000 -> 0x3800000000000000 at accept+2.
- With `SERIAL_NORM`=0, 0x00000001 gives 0x36A0000000000000 at accept+1.
- 0x7FA00000 (sNaN) -> 0x7FFC000000000000.
- 0x80000000 -> 0x8000000000000000.
- 0xFF800000 -> 0xFFF0000000000000.
- Hold `out_ready`=0 for 5 cycles in DONE:
  - `out_valid`, `out_data` and `in_ready`=0 stay stable and a presented `in_valid` is ignored;
  - releasing `out_ready` gives the handshake, then IDLE the next cycle.
- Assert `reset` during NORM of 0x00000001 -> `out_valid`=0, `out_data`=0 and `busy`=0 immediately. A following 0x3F800000 yields 0x3FF0000000000000.
